// File: rtl/final_pkg.sv
// Shared types, constants and fp32 helpers for the final decision stage.
package final_pkg;

  typedef logic [31:0] fp32_t;

  localparam fp32_t FP_ZERO = 32'h0000_0000;
  // Default detection threshold (0.5) used when integrating the block.
  localparam fp32_t FP_HALF = 32'h3F00_0000;

  // True for any NaN: all-ones exponent with a non-zero mantissa.
  function automatic logic fp32_is_nan(input fp32_t x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // ReLU on raw fp32 bits: negatives (including -0) and NaN collapse to +0.
  // +Inf and denormals pass through untouched.
  function automatic fp32_t fp32_relu(input fp32_t x);
    if (x[31] || fp32_is_nan(x)) begin
      return FP_ZERO;
    end
    return x;
  endfunction

endpackage

// File: rtl/fp32_gt.sv
// Combinational signed fp32 strict greater-than (a > b).
// Any NaN operand gives false; +0 and -0 compare equal.
module fp32_gt
  import final_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  output logic  gt
);

  logic a_zero;
  logic b_zero;

  assign a_zero = (a[30:0] == 31'd0);
  assign b_zero = (b[30:0] == 31'd0);

  // Sign-magnitude ordering: magnitudes compare as unsigned integers,
  // with the direction flipped when both operands are negative.
  always_comb begin
    gt = 1'b0;
    if (fp32_is_nan(a) || fp32_is_nan(b)) begin
      gt = 1'b0;
    end else if (a_zero && b_zero) begin
      gt = 1'b0;
    end else if (a[31] != b[31]) begin
      gt = ~a[31];
    end else if (!a[31]) begin
      gt = (a[30:0] > b[30:0]);
    end else begin
      gt = (a[30:0] < b[30:0]);
    end
  end

endmodule

// File: rtl/final_decision.sv
// Streaming multi-class decision stage: ReLU-clamps one frame of fp32
// scores, tracks the arg-max, thresholds it and debounces the detect flag.
module final_decision
  import final_pkg::*;
#(
  parameter  int N_CLASS  = 10,
  parameter  int DEBOUNCE = 1,
  localparam int IDX_W    = $clog2(N_CLASS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [31:0]      threshold,
  input  logic [31:0]      data_in,
  input  logic             valid_in,
  output logic             valid_out,
  output logic [IDX_W-1:0] class_idx,
  output logic [31:0]      max_score,
  output logic             hit,
  output logic             detect
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASS - 1);
  localparam logic [7:0]       DEB_MAX  = 8'(DEBOUNCE);

  logic [IDX_W-1:0] idx_reg;
  logic [IDX_W-1:0] idx_max_reg;
  fp32_t            run_max_reg;
  fp32_t            thr_reg;
  logic [7:0]       cnt_reg;

  fp32_t            beat_val;
  logic             first_beat;
  logic             last_beat;
  logic             accept;
  logic             beat_gt;
  logic             take_beat;
  fp32_t            frame_max;
  logic [IDX_W-1:0] frame_idx;
  fp32_t            thr_cur;
  logic             frame_hit;
  logic [7:0]       cnt_next;

  assign beat_val   = fp32_relu(data_in);
  assign first_beat = (idx_reg == '0);
  assign last_beat  = (idx_reg == LAST_IDX);
  assign accept     = valid_in & ~clear;

  // Beat 0 always loads; later beats replace only when strictly greater,
  // so ties keep the lowest index.
  fp32_gt u_gt_max (
    .a  (beat_val),
    .b  (run_max_reg),
    .gt (beat_gt)
  );

  assign take_beat = first_beat | beat_gt;
  assign frame_max = take_beat ? beat_val : run_max_reg;
  assign frame_idx = take_beat ? idx_reg  : idx_max_reg;
  // Threshold is captured on beat 0; bypass the register on that beat.
  assign thr_cur   = first_beat ? fp32_t'(threshold) : thr_reg;

  // The threshold stays unclamped so negative/NaN thresholds behave as signed fp32.
  fp32_gt u_gt_thr (
    .a  (frame_max),
    .b  (thr_cur),
    .gt (frame_hit)
  );

  // Saturating hit-streak count; any miss restarts the streak.
  always_comb begin
    cnt_next = 8'd0;
    if (frame_hit) begin
      cnt_next = (cnt_reg >= DEB_MAX) ? DEB_MAX : cnt_reg + 8'd1;
    end
  end

  // Beat counter and running arg-max / sampled threshold for the open frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg     <= '0;
      idx_max_reg <= '0;
      run_max_reg <= FP_ZERO;
      thr_reg     <= FP_ZERO;
    end else if (clear) begin
      idx_reg <= '0;
    end else if (valid_in) begin
      idx_reg     <= last_beat ? '0 : idx_reg + IDX_W'(1);
      run_max_reg <= frame_max;
      idx_max_reg <= frame_idx;
      if (first_beat) begin
        thr_reg <= threshold;
      end
    end
  end

  // Frame results, debounce state and the one-cycle result strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      class_idx <= '0;
      max_score <= FP_ZERO;
      hit       <= 1'b0;
      detect    <= 1'b0;
      cnt_reg   <= 8'd0;
    end else if (clear) begin
      valid_out <= 1'b0;
      detect    <= 1'b0;
      cnt_reg   <= 8'd0;
    end else begin
      valid_out <= accept & last_beat;
      if (accept && last_beat) begin
        class_idx <= frame_idx;
        max_score <= frame_max;
        hit       <= frame_hit;
        cnt_reg   <= cnt_next;
        detect    <= (cnt_next == DEB_MAX);
      end
    end
  end

endmodule

// File: tb/tb_final_decision.sv
// Bench for final_decision: two instances (DEBOUNCE=1 and DEBOUNCE=3) share
// one input stream and are compared every cycle against a frame-level model.
module tb_final_decision;
  import final_pkg::*;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] threshold = FP_HALF;
  logic [31:0] data_in = 32'h0;

  logic        v1, h1, d1, v3, h3, d3;
  logic [1:0]  c1, c3;
  logic [31:0] m1, m3;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model state
  logic [31:0] q[$];
  logic [31:0] thr_s;
  int          streak;
  logic        exp_valid, exp_hit, exp_det1, exp_det3;
  logic [31:0] exp_class, exp_max;
  logic [31:0] rnd_last = 32'h3F00_0000;

  always #5 clk = ~clk;

  final_decision #(.N_CLASS(N), .DEBOUNCE(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .threshold(threshold),
    .data_in(data_in), .valid_in(valid_in), .valid_out(v1),
    .class_idx(c1), .max_score(m1), .hit(h1), .detect(d1)
  );

  final_decision #(.N_CLASS(N), .DEBOUNCE(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .threshold(threshold),
    .data_in(data_in), .valid_in(valid_in), .valid_out(v3),
    .class_idx(c3), .max_score(m3), .hit(h3), .detect(d3)
  );

  function automatic logic is_nan(input logic [31:0] b);
    return (b[30:23] == 8'hFF) && (b[22:0] != 0);
  endfunction

  // Numeric value of an fp32 pattern (Inf as a huge real; NaN never reaches here).
  function automatic real fp2real(input logic [31:0] b);
    int  e;
    real mag;
    e = int'(b[30:23]);
    if (e == 255)    mag = 1.0e300;
    else if (e == 0) mag = real'(b[22:0]) * (2.0 ** (-149));
    else             mag = real'({1'b1, b[22:0]}) * (2.0 ** (e - 150));
    return b[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] clamp(input logic [31:0] b);
    return (b[31] || is_nan(b)) ? 32'h0 : b;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    logic        s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0: r = {s, 8'hFF, 23'($urandom) | 23'd1};
      1: r = {s, 8'hFF, 23'd0};
      2: r = {s, 31'd0};
      3: r = {s, 8'h00, 23'($urandom)};
      4: r = rnd_last;
      default: r = {s, 8'($urandom_range(120, 130)), 23'($urandom)};
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    q.delete();
    streak    = 0;
    exp_valid = 1'b0;
    exp_class = 0;
    exp_max   = 32'h0;
    exp_hit   = 1'b0;
    exp_det1  = 1'b0;
    exp_det3  = 1'b0;
  endtask

  task automatic eval_frame();
    int          best;
    real         bestv, r;
    logic [31:0] c;
    best = 0; bestv = 0.0; exp_max = 32'h0;
    for (int i = 0; i < N; i++) begin
      c = clamp(q[i]);
      r = fp2real(c);
      if (i == 0 || r > bestv) begin
        best = i; bestv = r; exp_max = c;
      end
    end
    exp_class = best;
    exp_hit   = !is_nan(thr_s) && (bestv > fp2real(thr_s));
    streak    = exp_hit ? streak + 1 : 0;
    exp_det1  = (streak >= 1);
    exp_det3  = (streak >= 3);
    exp_valid = 1'b1;
    q.delete();
  endtask

  task automatic model_step();
    exp_valid = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (clear) begin
      q.delete();
      streak   = 0;
      exp_det1 = 1'b0;
      exp_det3 = 1'b0;
    end else if (valid_in) begin
      if (q.size() == 0) thr_s = threshold;
      q.push_back(data_in);
      if (q.size() == N) eval_frame();
    end
  endtask

  task automatic check_all();
    chk("valid_d1", 32'(v1), 32'(exp_valid));
    chk("valid_d3", 32'(v3), 32'(exp_valid));
    chk("class_d1", 32'(c1), exp_class);
    chk("class_d3", 32'(c3), exp_class);
    chk("max_d1",   m1,      exp_max);
    chk("max_d3",   m3,      exp_max);
    chk("hit_d1",   32'(h1), 32'(exp_hit));
    chk("hit_d3",   32'(h3), 32'(exp_hit));
    chk("det_d1",   32'(d1), 32'(exp_det1));
    chk("det_d3",   32'(d3), 32'(exp_det3));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic beat(input logic [31:0] d);
    valid_in = 1'b1;
    data_in  = d;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic frame(input logic [31:0] f [N], input logic [31:0] thr, input int g);
    threshold = thr;
    for (int i = 0; i < N; i++) begin
      beat(f[i]);
      if (i < N - 1) gap(g);
    end
  endtask

  localparam logic [31:0] F_HITS [N] = '{32'h3E4CCCCD, 32'h3F666666, 32'hC0400000, 32'h3F333333};
  localparam logic [31:0] F_NEG  [N] = '{32'hBF800000, 32'h7FC00000, 32'h3F000000, 32'h3F000000};
  localparam logic [31:0] F_MISS [N] = '{32'h3DCCCCCD, 32'h3DCCCCCD, 32'h3DCCCCCD, 32'h3DCCCCCD};
  localparam logic [31:0] F_B2B  [N] = '{32'h3F800000, 32'h3F800001, 32'h3F800001, 32'h80000000};

  initial begin
    logic [31:0] f [N];
    logic        deb_exp [7];
    deb_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // reset state
    model_reset();
    gap(2);
    rst_n = 1'b1;
    tick();

    // basic arg-max
    frame(F_HITS, FP_HALF, 0);
    chk("basic_valid", 32'(v1), 32'd1);
    chk("basic_class", 32'(c1), 32'd1);
    chk("basic_max",   m1,      32'h3F666666);
    chk("basic_hit",   32'(h1), 32'd1);
    chk("basic_det",   32'(d1), 32'd1);
    gap(1);

    // negatives, tie, NaN
    frame(F_NEG, FP_HALF, 0);
    chk("neg_class", 32'(c1), 32'd2);
    chk("neg_max",   m1,      32'h3F000000);
    chk("neg_hit",   32'(h1), 32'd0);
    chk("neg_det",   32'(d1), 32'd0);
    gap(1);

    // debounce: hit hit miss hit hit hit miss
    for (int k = 0; k < 7; k++) begin
      frame((k == 2 || k == 6) ? F_MISS : F_HITS, FP_HALF, 0);
      chk("deb_det3", 32'(d3), 32'(deb_exp[k]));
    end

    // back-to-back frames, second with 2-cycle gaps
    frame(F_HITS, FP_HALF, 0);
    frame(F_B2B, 32'h3F800000, 2);
    chk("b2b_class", 32'(c1), 32'd1);
    gap(2);

    // clear together with beat 2
    frame(F_HITS, FP_HALF, 0);
    beat(32'h3F800000);
    beat(32'h3F800000);
    clear = 1'b1;
    beat(32'h40000000);
    clear = 1'b0;
    chk("clear_det", 32'(d1), 32'd0);
    frame(F_MISS, 32'hBF800000, 0);
    chk("clear_class", 32'(c1), 32'd0);
    chk("clear_max",   m1,      32'h3DCCCCCD);
    gap(1);

    // asynchronous reset after beat 1
    beat(32'h40000000);
    beat(32'h40400000);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    tick();
    rst_n = 1'b1;
    frame(F_HITS, FP_HALF, 0);
    chk("rst_class", 32'(c1), 32'd1);
    gap(1);

    // randomized frames with gaps, occasional clear and odd thresholds
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 2) == 0) threshold = rand_fp();
      else threshold = {1'b0, 8'd126, 23'($urandom)};
      for (int i = 0; i < N; i++) begin
        valid_in = 1'b1;
        data_in  = rand_fp();
        rnd_last = data_in;
        clear    = ($urandom_range(0, 49) == 0);
        tick();
        clear    = 1'b0;
        valid_in = 1'b0;
        if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 2));
      end
    end
    gap(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/final_decision.md
# final_decision

Streaming decision stage at the tail of the FC network. It replaces the single-output 0.5 comparator with a multi-class block. It accepts one frame of `N_CLASS` IEEE-754 single-precision scores, one per beat, and applies ReLU clamping. It then reports the arg-max class, its score and a thresholded detect flag, debounced across consecutive frames. It sits directly after the last FC layer's output stream and drives the system-level detect logic.

## Interface
Parameters:
- `N_CLASS`, 10: scores per frame; legal range 2..1024.
- `DEBOUNCE`, 1: consecutive hit frames required to assert `detect`; 1 means no debounce; legal range 1..255.
- `IDX_W`, `$clog2(N_CLASS)`: width of the class index; derived, not overridden.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clear` in 1: synchronous abort; drops the partial frame and zeroes the debounce count.
- `threshold` in 32: fp32 threshold; sampled on the first beat of each frame.
- `data_in` in 32: fp32 score.
- `valid_in` in 1: `data_in` beat is valid; there is no backpressure.
- `valid_out` out 1: one-cycle pulse; the result outputs are updated.
- `class_idx` out IDX_W: arg-max index of the last frame.
- `max_score` out 32: clamped maximum score of the last frame.
- `hit` out 1: `max_score > threshold` for the last frame.
- `detect` out 1: debounced detect; held between frames.

## Operation
- Beat counter `idx` runs 0..N_CLASS-1 and advances on each `valid_in`. It wraps to 0 after beat N_CLASS-1. The beat with `idx==N_CLASS-1` is the frame's last beat.
- Clamp rule, applied to every beat:
  - sign=1, including -0, maps to +0.
  - NaN (exp=0xFF, mant!=0) maps to +0.
  - +Inf passes through unchanged.
  - Denormals are compared as-is.
- Because clamped values are non-negative, the fp32 greater-than reduces to an unsigned compare on bits [30:0]. The threshold must not be clamped. It uses a full signed fp32 compare:
  - A negative threshold makes every frame a hit.
  - A NaN threshold makes every frame a miss.
- Arg-max:
  - Beat 0 loads the running max and sets `idx_max=0`.
  - A later beat replaces them only if strictly greater.
  - On ties, the lowest index wins.
- Frame end: `hit` = clamped max > sampled threshold (strict).
- Debounce counter `cnt` (8 bits, saturating at `DEBOUNCE`):
  - A hit frame increments it.
  - A miss frame zeroes it.
  - `detect` = (`cnt` after update == `DEBOUNCE`).
- `clear`:
  - Sets `idx` to 0 and `cnt` to 0, and deasserts `detect`.
  - Suppresses any `valid_out` for the current cycle's beat.
  - Leaves `class_idx`, `max_score` and `hit` unchanged.

## Timing
- Reset values: `valid_out`=0, `class_idx`=0, `max_score`=0x00000000, `hit`=0, `detect`=0, `idx`=0, `cnt`=0.
- Latency: `valid_out` pulses the cycle after the last beat is accepted. `class_idx`, `max_score`, `hit` and `detect` update on that same edge and hold until the next `valid_out`.
- Frames may be back-to-back: beat 0 of frame k+1 may arrive in the cycle `valid_out` of frame k is high.
- Gaps (`valid_in`=0) mid-frame are legal and do not change state.
- `clear` together with `valid_in` in the same cycle: `clear` wins, the beat is dropped and the next beat is beat 0.
- An async reset mid-frame discards the partial frame. The next accepted beat is beat 0.
- `valid_out` is never high for two consecutive cycles, because N_CLASS≥2.

## Structure
- Package `final_pkg` holds:
  - typedef `fp32_t` (32-bit logic);
  - constants `FP_ZERO`=32'h00000000 and `FP_HALF`=32'h3F000000, the default threshold for integration;
  - functions `fp32_relu` and `fp32_is_nan`.
- One sub-module, `fp32_gt`: a combinational signed fp32 strict greater-than. It handles NaN (always false) and ±0 (treated as equal). It is instantiated twice: once for the running max and once for the threshold compare.
- Everything else (counter, arg-max register, debounce) lives in `final_decision`.

## Test plan
- **Basic arg-max.** N_CLASS=4, DEBOUNCE=1, threshold=0x3F000000. Scores {0.2, 0.9, -3.0, 0.7} → one cycle after beat 3: `valid_out`=1, `class_idx`=1, `max_score`=0x3F666666, `hit`=1, `detect`=1.
- **Negatives, tie and NaN.** Scores {-1.0, 0x7FC00000, 0.5, 0.5} → `class_idx`=2, `max_score`=0x3F000000, `hit`=0 (strict compare), `detect`=0.
- **Debounce.** DEBOUNCE=3; frames hit, hit, miss, hit, hit, hit → `detect` stays 0 until the 6th `valid_out`, then 1; a following miss frame gives `detect`=0.
- **Back-to-back frames with gaps.** Two frames with no idle cycle between them, where the second has 2-cycle gaps mid-frame → exactly two `valid_out` pulses, each one cycle after its last beat, with correct per-frame results.
- **Clear.** `clear` asserted together with beat 2 of 4, then 4 new beats → a single `valid_out` computed from the new 4 beats only; `detect` was forced to 0 on the clear cycle.
- **Reset mid-frame.** `rst_n` is low for 1 cycle after beat 1; afterwards every output is at its reset value, and the next full frame produces the correct result with `idx` restarted at 0.
